ul4_bist: RTL and testbench
===========================

// Module: ul4_bist
// PURPOSE
//  Self-test controller for the 4-function logic unit ul4 (AND/OR/XOR/NOT).
//  Drives the unit's A, B and S inputs and checks its Out. Sweeps every (S, A, B)
//  combination, compares Out against a golden model and reports pass/fail,
//  error count and the first failing vector. Sits beside ul4 in the ALU
//  datapath and runs in the field or in simulation without a testbench.
// PARAMETERS
//  WIDTH  4  operand width; must match the ul4 instance
//  ERR_W  8  width of the saturating mismatch counter
// PORTS
//  clk       in   1        rising-edge clock
//  rst       in   1        synchronous, active-high reset
//  start     in   1        begin a sweep; sampled in IDLE or DONE only
//  op_a      out  WIDTH    to ul4 A (registered)
//  op_b      out  WIDTH    to ul4 B (registered)
//  op_sel    out  2        to ul4 S (registered)
//  ul_out    in   WIDTH    from ul4 Out (combinational from op_*)
//  busy      out  1        high while in RUN
//  done      out  1        high in DONE, held until the next start or rst
//  pass      out  1        done && err_count==0
//  err_count out  ERR_W    mismatches this sweep; saturates at 2^ERR_W-1
//  fail_ops  out  4        sticky per-S mismatch flags, bit i = S==i
//  fail_a/fail_b/fail_sel out WIDTH/WIDTH/2  first mismatching vector
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0, including op_* and the capture registers.
//  Vector counter vec = {sel, a, b}, 2+2*WIDTH bits; b is the LSB field.
//  op_* = the counter fields. Golden: 00 a&b, 01 a|b, 10 a^b, 11 ~a. B is don't-care for 11 but is still swept.
//  FSM: IDLE --start--> RUN; RUN --last vector compared--> DONE; DONE --start--> RUN.
//  On the start edge: vec <- 0; err_count, fail_ops and the capture registers are cleared.
//  RUN: each edge compares ul_out with golden(op_*) and then increments vec. One vector per cycle.
//  Compare happens the cycle after the vector is driven. ul4 is combinational, so there is zero extra latency.
//  Sweep length is 4*2^(2*WIDTH) cycles: start edge k, compares at edges k+1 .. k+N, done rises after edge k+N.
//  Mismatch: err_count+1 (saturating); fail_ops[op_sel] <- 1. On the first mismatch only, fail_a/b/sel capture op_*.
//  start while in RUN is ignored. start and the last compare on the same edge: the last compare wins, DONE is entered, start is dropped.
//  On the final vector vec wraps to 0 and op_* read 0 in DONE.
//  rst mid-sweep returns to IDLE on that edge; all results are lost.
// CONFIGURATION
//  UL4_BIST_STOP_ON_FAIL_EN defined: the first mismatch moves RUN->DONE on the same edge.
//   In that case op_* keep the failing vector and err_count = 1.
//  Not defined: the sweep always runs to completion. Capture registers still hold the first failure.
// STRUCTURE
//  ul4_pkg holds: op encodings OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NOT=2'b11;
//   the state enum {IDLE, RUN, DONE}; and function ul4_golden(sel, a, b).
//  One sub-module is natural: ul4_bist_gen, the vector counter with a last-vector flag.
//  FSM, comparator and result registers stay in ul4_bist.
// TESTING
//  Bench: WIDTH=4, ul4_bist wired to ul4, sweep length N = 1024.
//  1. Good ul4, start pulse -> busy high 1024 cycles; done=1, pass=1, err_count=0, fail_ops=0000.
//  2. Faulty ul4 (S=01 returns A&B) -> done, pass=0, err_count=240, fail_ops=0010;
//     first failure fail_sel=01, fail_a=0000, fail_b=0001.
//  3. Same fault, UL4_BIST_STOP_ON_FAIL_EN defined -> done after 258 compare cycles;
//     err_count=1, op_sel=01, op_a=0000, op_b=0001.
//  4. rst asserted at cycle 300 of a sweep -> next cycle IDLE, all outputs 0; a new start gives a full clean sweep.
//  5. start re-pulsed during RUN -> ignored, done still after exactly 1024 cycles.
//     start in DONE -> err_count and fail_* cleared, new sweep begins.
//  6. Stuck-at-0 on ul4 Out[3] -> fail_ops=1111. err_count saturates at 255 (true count > 255).

Source files
------------

// File: rtl/ul4_pkg.sv
// Shared definitions for the ul4 logic unit and its self-test controller:
// op encodings, BIST state type and the golden reference function.
package ul4_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Evaluated at 32 bits; callers truncate to their operand width.
  function automatic logic [31:0] ul4_golden(input logic [1:0] sel,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0] res;
    case (sel)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NOT:  res = ~a;
      default: res = 32'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ul4_bist_if.sv
// Operand/result bus between the BIST controller (master) and ul4 (slave).
interface ul4_bist_if #(parameter int WIDTH = 4);
  import ul4_pkg::*;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] ul_out;

  modport master (output op_a, output op_b, output op_sel, input ul_out);
  modport slave  (input op_a, input op_b, input op_sel, output ul_out);
endinterface

// File: rtl/ul4_bist_gen.sv
// Test vector counter {sel, a, b}; flags the final vector of the sweep.
module ul4_bist_gen
  import ul4_pkg::*;
#(
  parameter int VW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic [VW-1:0] o_vec,
  output logic          o_last
);

  logic [VW-1:0] r_vec;

  // Counter wraps to zero after the last vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vec <= {VW{1'b0}};
    end else if (i_clr) begin
      r_vec <= {VW{1'b0}};
    end else if (i_inc) begin
      r_vec <= r_vec + {{(VW-1){1'b0}}, 1'b1};
    end else begin
      r_vec <= r_vec;
    end
  end

  assign o_vec  = r_vec;
  assign o_last = &r_vec;

endmodule

// File: rtl/ul4_bist.sv
// Self-test controller for ul4: sweeps all (S,A,B), compares against golden.
// Optional UL4_BIST_STOP_ON_FAIL_EN: end the sweep on the first mismatch.
module ul4_bist
  import ul4_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  ul4_bist_if.master       bus,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [ERR_W-1:0] o_err_count,
  output logic [3:0]       o_fail_ops,
  output logic [WIDTH-1:0] o_fail_a,
  output logic [WIDTH-1:0] o_fail_b,
  output logic [1:0]       o_fail_sel
);

  localparam int VW = 2 + 2 * WIDTH;

  state_e           r_state;
  logic [ERR_W-1:0] r_err;
  logic [3:0]       r_fail_ops;
  logic [WIDTH-1:0] r_fail_a;
  logic [WIDTH-1:0] r_fail_b;
  logic [1:0]       r_fail_sel;

  logic [VW-1:0]    w_vec;
  logic             w_last;
  logic [WIDTH-1:0] w_golden;
  logic             w_mismatch;
  logic             w_start_ok;
  logic             w_stop;
  logic             w_inc;

  assign w_start_ok = i_start && ((r_state == IDLE) || (r_state == DONE));
  assign w_golden   = WIDTH'(ul4_golden(bus.op_sel, 32'(bus.op_a), 32'(bus.op_b)));
  assign w_mismatch = (r_state == RUN) && (bus.ul_out != w_golden);
`ifdef UL4_BIST_STOP_ON_FAIL_EN
  assign w_stop = w_mismatch;
`else
  assign w_stop = 1'b0;
`endif
  // A stopping mismatch freezes the counter so op_* keep the failing vector.
  assign w_inc = (r_state == RUN) && !w_stop;

  ul4_bist_gen #(.VW(VW)) u_gen (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_start_ok),
    .i_inc  (w_inc),
    .o_vec  (w_vec),
    .o_last (w_last)
  );

  assign bus.op_sel = w_vec[VW-1 -: 2];
  assign bus.op_a   = w_vec[2*WIDTH-1 -: WIDTH];
  assign bus.op_b   = w_vec[WIDTH-1:0];

  // FSM plus result capture; err==0 marks that no failure was captured yet.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_err      <= {ERR_W{1'b0}};
      r_fail_ops <= 4'b0000;
      r_fail_a   <= {WIDTH{1'b0}};
      r_fail_b   <= {WIDTH{1'b0}};
      r_fail_sel <= 2'b00;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_start_ok) begin
            r_state    <= RUN;
            r_err      <= {ERR_W{1'b0}};
            r_fail_ops <= 4'b0000;
            r_fail_a   <= {WIDTH{1'b0}};
            r_fail_b   <= {WIDTH{1'b0}};
            r_fail_sel <= 2'b00;
          end
        end
        RUN: begin
          if (w_mismatch) begin
            if (!(&r_err)) begin
              r_err <= r_err + {{(ERR_W-1){1'b0}}, 1'b1};
            end
            r_fail_ops[bus.op_sel] <= 1'b1;
            if (r_err == {ERR_W{1'b0}}) begin
              r_fail_a   <= bus.op_a;
              r_fail_b   <= bus.op_b;
              r_fail_sel <= bus.op_sel;
            end
          end
          if (w_last || w_stop) begin
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy      = (r_state == RUN);
  assign o_done      = (r_state == DONE);
  assign o_pass      = (r_state == DONE) && (r_err == {ERR_W{1'b0}});
  assign o_err_count = r_err;
  assign o_fail_ops  = r_fail_ops;
  assign o_fail_a    = r_fail_a;
  assign o_fail_b    = r_fail_b;
  assign o_fail_sel  = r_fail_sel;

endmodule

// File: tb/tb_ul4_bist.sv
// Directed bench: ul4_bist wired to a behavioural ul4 with injectable faults.
module tb_ul4_bist;

  localparam int WIDTH = 4;
  localparam int ERR_W = 8;
  localparam int N     = 1024;

`ifdef UL4_BIST_STOP_ON_FAIL_EN
  localparam int         OR_LEN  = 258;
  localparam int         OR_ERR  = 1;
  localparam logic [3:0] OR_A_END = 4'h0, OR_B_END = 4'h1;
  localparam logic [1:0] OR_S_END = 2'b01;
  localparam int         SA_LEN  = 137;
  localparam int         SA_ERR  = 1;
  localparam logic [3:0] SA_OPS  = 4'b0001;
  localparam logic [3:0] SA_A_END = 4'h8, SA_B_END = 4'h8;
`else
  localparam int         OR_LEN  = N;
  localparam int         OR_ERR  = 240;
  localparam logic [3:0] OR_A_END = 4'h0, OR_B_END = 4'h0;
  localparam logic [1:0] OR_S_END = 2'b00;
  localparam int         SA_LEN  = N;
  localparam int         SA_ERR  = 255;
  localparam logic [3:0] SA_OPS  = 4'b1111;
  localparam logic [3:0] SA_A_END = 4'h0, SA_B_END = 4'h0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             i_start = 1'b0;
  logic             o_busy, o_done, o_pass;
  logic [ERR_W-1:0] o_err_count;
  logic [3:0]       o_fail_ops;
  logic [WIDTH-1:0] o_fail_a, o_fail_b;
  logic [1:0]       o_fail_sel;
  int               fault = 0;
  int               total = 0;
  int               bad = 0;
  int               cyc;

  ul4_bist_if #(.WIDTH(WIDTH)) bus ();

  ul4_bist #(.WIDTH(WIDTH), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .bus(bus),
    .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass),
    .o_err_count(o_err_count), .o_fail_ops(o_fail_ops),
    .o_fail_a(o_fail_a), .o_fail_b(o_fail_b), .o_fail_sel(o_fail_sel)
  );

  always #5 clk = ~clk;

  // Behavioural ul4: fault 1 = OR returns AND, fault 2 = Out[3] stuck at 0.
  always_comb begin
    logic [WIDTH-1:0] r;
    case (bus.op_sel)
      2'b00:   r = bus.op_a & bus.op_b;
      2'b01:   r = (fault == 1) ? (bus.op_a & bus.op_b) : (bus.op_a | bus.op_b);
      2'b10:   r = bus.op_a ^ bus.op_b;
      default: r = ~bus.op_a;
    endcase
    if (fault == 2) r[3] = 1'b0;
    bus.ul_out = r;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // Counts negedges with busy high; optionally re-pulses start mid-run.
  task automatic count_busy(input int repulse_at, output int n);
    n = 0;
    while (o_busy && n < 2000) begin
      n++;
      i_start = (n == repulse_at);
      @(negedge clk);
    end
    i_start = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_done"}, 32'(o_done), 32'd0);
    chk({tag, "_pass"}, 32'(o_pass), 32'd0);
    chk({tag, "_err"}, 32'(o_err_count), 32'd0);
    chk({tag, "_ops"}, 32'(o_fail_ops), 32'd0);
    chk({tag, "_fail"}, {20'd0, o_fail_sel, o_fail_a, o_fail_b}, 32'd0);
    chk({tag, "_op"}, {22'd0, bus.op_sel, bus.op_a, bus.op_b}, 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(o_busy), 32'd0);

    // Good unit, full sweep
    pulse_start();
    chk("t1_busy_start", 32'(o_busy), 32'd1);
    count_busy(0, cyc);
    chk("t1_len", 32'(cyc), 32'(N));
    chk("t1_done", 32'(o_done), 32'd1);
    chk("t1_pass", 32'(o_pass), 32'd1);
    chk("t1_err", 32'(o_err_count), 32'd0);
    chk("t1_ops", 32'(o_fail_ops), 32'd0);
    chk("t1_op_wrap", {22'd0, bus.op_sel, bus.op_a, bus.op_b}, 32'd0);
    @(negedge clk);
    chk("t1_done_held", 32'(o_done), 32'd1);

    // OR behaves as AND
    fault = 1;
    pulse_start();
    count_busy(0, cyc);
    chk("t2_len", 32'(cyc), 32'(OR_LEN));
    chk("t2_done", 32'(o_done), 32'd1);
    chk("t2_pass", 32'(o_pass), 32'd0);
    chk("t2_err", 32'(o_err_count), 32'(OR_ERR));
    chk("t2_ops", 32'(o_fail_ops), 32'b0010);
    chk("t2_fsel", 32'(o_fail_sel), 32'b01);
    chk("t2_fa", 32'(o_fail_a), 32'h0);
    chk("t2_fb", 32'(o_fail_b), 32'h1);
    chk("t2_op_end", {22'd0, bus.op_sel, bus.op_a, bus.op_b},
        {22'd0, OR_S_END, OR_A_END, OR_B_END});

    // Start in DONE clears results; re-pulse during RUN is ignored
    fault = 0;
    pulse_start();
    chk("t5_busy", 32'(o_busy), 32'd1);
    chk("t5_err_clr", 32'(o_err_count), 32'd0);
    chk("t5_ops_clr", 32'(o_fail_ops), 32'd0);
    chk("t5_fail_clr", {20'd0, o_fail_sel, o_fail_a, o_fail_b}, 32'd0);
    count_busy(100, cyc);
    chk("t5_len", 32'(cyc), 32'(N));
    chk("t5_pass", 32'(o_pass), 32'd1);

    // Reset mid-sweep, then a clean sweep
    fault = 2;
    pulse_start();
    repeat (299) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("t4_rst");
    fault = 0;
    pulse_start();
    count_busy(0, cyc);
    chk("t4_len", 32'(cyc), 32'(N));
    chk("t4_pass", 32'(o_pass), 32'd1);
    chk("t4_err", 32'(o_err_count), 32'd0);

    // Stuck-at-0 on Out[3]
    fault = 2;
    pulse_start();
    count_busy(0, cyc);
    chk("t6_len", 32'(cyc), 32'(SA_LEN));
    chk("t6_pass", 32'(o_pass), 32'd0);
    chk("t6_err", 32'(o_err_count), 32'(SA_ERR));
    chk("t6_ops", 32'(o_fail_ops), 32'(SA_OPS));
    chk("t6_fail", {20'd0, o_fail_sel, o_fail_a, o_fail_b}, {20'd0, 2'b00, 4'h8, 4'h8});
    chk("t6_op_end", {22'd0, bus.op_sel, bus.op_a, bus.op_b},
        {22'd0, 2'b00, SA_A_END, SA_B_END});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
